// File: rtl/ann_pkg.sv
// ann_pkg: shared constants, Q8.8 saturation limits and FSM states for the neuron MAC datapath.
package ann_pkg;
   localparam int N_INPUTS  = 28;
   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 16;
   localparam int ACC_W     = 40;
   localparam int FRAC_BITS = 8;
   localparam logic [DATA_W-1:0] QMAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] QMIN = 16'h8000;
   localparam logic signed [ACC_W-1:0] QMAX_EXT = 40'sd32767;
   localparam logic signed [ACC_W-1:0] QMIN_EXT = -40'sd32768;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
   // Q16.16 sum -> Q8.8 by arithmetic shift (floor), clamped to the 16-bit range
   function automatic logic [DATA_W-1:0] sat_q88(input logic signed [ACC_W-1:0] s);
      logic signed [ACC_W-1:0] q;
      q = s >>> FRAC_BITS;
      return (q > QMAX_EXT) ? QMAX : (q < QMIN_EXT) ? QMIN : q[DATA_W-1:0];
   endfunction
endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// neuron_mac_sequencer_if: control, BRAM read and result signals of one neuron MAC stage.
interface neuron_mac_sequencer_if;
   import ann_pkg::*;
   logic                     START;
   logic signed [DATA_W-1:0] BIAS;
   logic [ADDR_W-1:0]        ADDR;
   logic                     EN;
   logic                     WE;
   logic signed [DATA_W-1:0] W_DO;
   logic signed [DATA_W-1:0] X_DO;
   logic [DATA_W-1:0]        RESULT;
   logic                     DONE;
   logic                     BUSY;
   modport master (output START, BIAS, W_DO, X_DO, input ADDR, EN, WE, RESULT, DONE, BUSY);
   modport slave  (input START, BIAS, W_DO, X_DO, output ADDR, EN, WE, RESULT, DONE, BUSY);
endinterface

// File: rtl/neuron_mac_sequencer_mac_unit.sv
// mac_unit: registers weight*activation when enabled, accumulates the registered product when valid.
module mac_unit
   import ann_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     en,
   input  logic                     valid,
   input  logic signed [DATA_W-1:0] w,
   input  logic signed [DATA_W-1:0] x,
   output logic signed [ACC_W-1:0]  acc
);
   logic signed [2*DATA_W-1:0] prod;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prod <= '0;
         acc  <= '0;
      end else begin
         if (en) prod <= w * x;
         acc <= clear ? '0 : valid ? acc + ACC_W'(prod) : acc;
      end
endmodule

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: walks the weight BRAM/activation buffer, MACs the pairs, adds bias, saturates to Q8.8.
// Optional NEURON_RELU_EN clamps negative results to zero.
module neuron_mac_sequencer
   import ann_pkg::*;
(
   input  logic CLK,
   input  logic RST_N,
   neuron_mac_sequencer_if.slave bus
);
   state_t                   state, state_nx;
   logic [ADDR_W-1:0]        addr_nx;
   logic                     en_nx, valid, clear;
   logic signed [DATA_W-1:0] bias, bias_nx;
   logic signed [ACC_W-1:0]  acc, sum;
   logic [DATA_W-1:0]        result, sat, res_val;

   mac_unit u_mac (
      .clk(CLK), .rst_n(RST_N), .clear(clear), .en(bus.EN), .valid(valid),
      .w(bus.W_DO), .x(bus.X_DO), .acc(acc)
   );

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state    <= IDLE;
         bus.ADDR <= '0;
         bus.EN   <= 1'b0;
         bias     <= '0;
         valid    <= 1'b0;
         result   <= '0;
      end else begin
         state    <= state_nx;
         bus.ADDR <= addr_nx;
         bus.EN   <= en_nx;
         bias     <= bias_nx;
         valid    <= bus.EN;
         if (state == FINISH) result <= res_val;
      end

   always_comb begin
      state_nx = state;
      addr_nx  = bus.ADDR;
      en_nx    = bus.EN;
      bias_nx  = bias;
      clear    = 1'b0;
      case (state)
         IDLE: if (bus.START) begin
            state_nx = ISSUE;
            addr_nx  = '0;
            en_nx    = 1'b1;
            bias_nx  = bus.BIAS;
            clear    = 1'b1;
         end
         ISSUE: if (bus.ADDR == ADDR_W'(N_INPUTS - 1)) begin
            state_nx = DRAIN;
            en_nx    = 1'b0;
         end else addr_nx = bus.ADDR + ADDR_W'(1);
         DRAIN:   state_nx = FINISH;
         default: state_nx = IDLE;
      endcase
   end

   // bias is Q8.8; shift it into the Q16.16 accumulator domain before adding
   assign sum = acc + (ACC_W'(bias) <<< FRAC_BITS);
   assign sat = sat_q88(sum);
`ifdef NEURON_RELU_EN
   assign res_val = sat[DATA_W-1] ? '0 : sat;
`else
   assign res_val = sat;
`endif

   // RESULT is presented combinationally in the DONE cycle, then held by the register
   assign bus.RESULT = (state == FINISH) ? res_val : result;
   assign bus.DONE   = state == FINISH;
   assign bus.BUSY   = state != IDLE;
   assign bus.WE     = 1'b0;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb_neuron_mac_sequencer: directed checks of timing, arithmetic, saturation, busy/bias/reset corner cases.
module tb_neuron_mac_sequencer;
   import ann_pkg::*;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   logic signed [DATA_W-1:0] wmem [0:31];
   logic signed [DATA_W-1:0] xmem [0:31];

   neuron_mac_sequencer_if bus ();
   neuron_mac_sequencer dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

   always #5 CLK = ~CLK;

   // BRAM model: reads on negedge while enabled, junk otherwise so ungated sampling shows up
   always @(negedge CLK)
      if (bus.EN) begin
         bus.W_DO <= wmem[bus.ADDR];
         bus.X_DO <= xmem[bus.ADDR];
      end else begin
         bus.W_DO <= DATA_W'($urandom);
         bus.X_DO <= DATA_W'($urandom);
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [15:0] w, input logic [15:0] x);
      for (int i = 0; i < 32; i++) begin
         wmem[i] = w;
         xmem[i] = x;
      end
   endtask

   // START is sampled at the posedge ending cycle 0; samples taken #1 into each later cycle
   task automatic run(input string tag, input logic [15:0] b, input logic [15:0] b_late,
                      input bit pulse_busy, input logic [15:0] exp);
      int c, en_cnt, done_c, dones;
      bit addr_ok;
      @(posedge CLK); #1;
      bus.START = 1'b1;
      bus.BIAS  = b;
      @(posedge CLK); #1;
      bus.START = 1'b0;
      c = 1; en_cnt = 0; done_c = 0; dones = 0; addr_ok = 1'b1;
      while (c < 70) begin
         if (c == 1) bus.BIAS = b_late;
         if (pulse_busy) bus.START = (c == 5 || c == 10);
         if (bus.EN) begin
            if (bus.ADDR != ADDR_W'(en_cnt)) addr_ok = 1'b0;
            en_cnt++;
         end
         if (bus.DONE) begin
            dones++;
            if (done_c == 0) begin
               done_c = c;
               check({tag, "_result"}, 32'(bus.RESULT), 32'(exp));
            end
         end
         if (done_c != 0 && !pulse_busy) break;
         @(posedge CLK); #1;
         c++;
      end
      bus.START = 1'b0;
      check({tag, "_done_cycle"}, 32'(done_c), 32'd30);
      check({tag, "_en_cycles"}, 32'(en_cnt), 32'd28);
      check({tag, "_addr_seq"}, 32'(addr_ok), 32'd1);
      if (pulse_busy) check({tag, "_done_count"}, 32'(dones), 32'd1);
      else begin
         @(posedge CLK); #1;
         check({tag, "_done_drop"}, 32'(bus.DONE), 32'd0);
         check({tag, "_hold"}, 32'(bus.RESULT), 32'(exp));
      end
   endtask

   initial begin
      logic [15:0] neg_exp;
      bit saw_done;
`ifdef NEURON_RELU_EN
      neg_exp = 16'h0000;
`else
      neg_exp = 16'hC900;
`endif
      bus.START = 1'b0;
      bus.BIAS  = '0;
      load(16'h0100, 16'h0100);
      #12;
      check("rst_outputs", {bus.ADDR, bus.EN, bus.WE, bus.DONE, bus.BUSY, bus.RESULT}, '0);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      check("idle_busy", 32'(bus.BUSY), 32'd0);

      run("unit", 16'h0000, 16'h0000, 1'b0, 16'h1C00);
      load(16'h7FFF, 16'h7FFF);
      run("possat", 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF);

      load(16'h0100, 16'h0100);
      @(posedge CLK); #1;
      bus.START = 1'b1;
      @(posedge CLK); #1;
      bus.START = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c < 12; c++) begin
         saw_done |= bus.DONE;
         @(posedge CLK); #1;
      end
      RST_N = 1'b0;
      #1;
      check("midrst_outputs", {bus.ADDR, bus.EN, bus.WE, bus.DONE, bus.BUSY, bus.RESULT}, '0);
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK); #1;
         saw_done |= bus.DONE;
      end
      RST_N = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge CLK); #1;
         saw_done |= bus.DONE;
      end
      check("midrst_no_done", 32'(saw_done), 32'd0);
      check("midrst_result", 32'(bus.RESULT), 32'd0);
      run("after_rst", 16'h0000, 16'h0000, 1'b0, 16'h1C00);

      load(16'hFF00, 16'h0200);
      run("negative", 16'h0100, 16'h0100, 1'b0, neg_exp);
      load(16'h0100, 16'h0100);
      run("busy_start", 16'h0000, 16'h0000, 1'b1, 16'h1C00);
      run("bias_late", 16'h0000, 16'h7FFF, 1'b0, 16'h1C00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
